macc_p_sequencer: RTL and testbench

Drives one `dsp_macc_p`-style DSP48E multiply-accumulate slice through a complete fit scalar product. It accepts a fit request (intercept plus a stream of NTERMS hit/constant pairs) and issues the A/B/C/OPMODE/CE sequence with correct pipeline alignment. It then collects the slice output, applies the final round-half-up of the spare LSB, and returns one rounded result with an overflow flag over a valid/ready handshake. The block sits between the fit-term fetch logic and the MACC slice in each fitter lane.

---
 rtl/macc_p_sequencer.sv | 159 +++++++++++++++
 tb/tb_macc_p_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_p_sequencer.sv
// macc_p_sequencer: sequences one DSP48E-style MACC slice through a fit
// scalar product (intercept + NTERMS products), then rounds the spare LSB
// of the slice output and returns the result over a valid/ready handshake.
//
// Handshakes (all three follow the same rule): a transfer happens on the
// rising CLK_IN edge where the producer's valid and the consumer's ready are
// both high. START_IN pairs with READY_OUT, TERM_VALID_IN with
// TERM_READY_OUT, and RESULT_VALID_OUT with RESULT_READY_IN. Once
// RESULT_VALID_OUT is high, RESULT_OUT/RESULT_OVF_OUT do not change until
// the transfer completes.
module macc_p_sequencer #(
  parameter int NTERMS   = 6,
  parameter int outwidth = 15
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic                START_IN,
  output logic                READY_OUT,
  input  logic [17:0]         INTERCEPT_IN,
  input  logic                TERM_VALID_IN,
  input  logic [17:0]         TERM_A_IN,
  input  logic [15:0]         TERM_B_IN,
  output logic                TERM_READY_OUT,
  output logic [17:0]         MACC_A_OUT,
  output logic [15:0]         MACC_B_OUT,
  output logic [17:0]         MACC_C_OUT,
  output logic [6:0]          MACC_OPMODE_OUT,
  output logic                MACC_CE_OUT,
  output logic                MACC_RST_OUT,
  input  logic [outwidth-1:0] MACC_P_IN,
  input  logic                MACC_OVF_IN,
  output logic [outwidth-2:0] RESULT_OUT,
  output logic                RESULT_OVF_OUT,
  output logic                RESULT_VALID_OUT,
  input  logic                RESULT_READY_IN,
  output logic [1:0]          DBG_STATE_OUT
);

  localparam int CW = $clog2(NTERMS + 1);
  localparam logic [CW-1:0] LAST_TERM = CW'(NTERMS - 1);

  // Z=C, Y=M, X=M: start a new sum from the intercept.
  localparam logic [6:0] OPMODE_LOAD = 7'h35;
  // Z=P, Y=M, X=M: accumulate onto the running sum.
  localparam logic [6:0] OPMODE_ACC  = 7'h25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       term_cnt;
  logic [1:0]          drain_cnt;
  logic [17:0]         intercept_q;
  logic                first_q;
  logic                start_acc, term_acc, last_acc, capture, result_acc;
  logic [outwidth-2:0] p_hi, r_sum, r_val;
  logic                sat;

  assign READY_OUT        = (state_q == IDLE);
  assign TERM_READY_OUT   = (state_q == ISSUE);
  assign RESULT_VALID_OUT = (state_q == DONE);
  assign DBG_STATE_OUT    = state_q;

  assign start_acc  = START_IN & READY_OUT;
  assign term_acc   = TERM_VALID_IN & TERM_READY_OUT;
  assign last_acc   = term_acc & (term_cnt == LAST_TERM);
  // The last product reaches PREG three edges after its accept, so the
  // capture edge is the fourth edge after the last accept.
  assign capture    = (state_q == DRAIN) & (drain_cnt == 2'd3);
  assign result_acc = RESULT_VALID_OUT & RESULT_READY_IN;

  assign MACC_C_OUT  = intercept_q;
  assign MACC_CE_OUT = ~RST_IN;

  // State register.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc)  state_d = ISSUE;
      ISSUE:   if (last_acc)   state_d = DRAIN;
      DRAIN:   if (capture)    state_d = DONE;
      DONE:    if (result_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Term and drain counters; the drain counter idles at zero outside DRAIN.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      term_cnt  <= '0;
      drain_cnt <= 2'd0;
    end else begin
      if (start_acc)     term_cnt <= '0;
      else if (term_acc) term_cnt <= term_cnt + CW'(1);
      if (state_q == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                  drain_cnt <= 2'd0;
    end
  end

  // Operand registers: a stalled cycle issues a zero product (bubble).
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      intercept_q <= '0;
      MACC_A_OUT  <= '0;
      MACC_B_OUT  <= '0;
    end else begin
      if (start_acc) intercept_q <= INTERCEPT_IN;
      MACC_A_OUT <= term_acc ? TERM_A_IN : 18'd0;
      MACC_B_OUT <= term_acc ? TERM_B_IN : 16'd0;
    end
  end

  // OPMODE trails the A/B load by one edge so it meets the product at MREG.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      first_q         <= 1'b0;
      MACC_OPMODE_OUT <= OPMODE_ACC;
    end else begin
      first_q         <= term_acc & (term_cnt == '0);
      MACC_OPMODE_OUT <= first_q ? OPMODE_LOAD : OPMODE_ACC;
    end
  end

  // Slice reset: set with RST_IN, released on the first edge afterwards.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) MACC_RST_OUT <= 1'b1;
    else        MACC_RST_OUT <= 1'b0;
  end

  // Round half up on the spare LSB; only the largest positive half can wrap.
  always_comb begin
    p_hi  = MACC_P_IN[outwidth-1:1];
    r_sum = p_hi + {{(outwidth-2){1'b0}}, MACC_P_IN[0]};
    sat   = ~MACC_P_IN[outwidth-1] & (&MACC_P_IN[outwidth-2:1]) & MACC_P_IN[0];
    r_val = sat ? {1'b0, {(outwidth-2){1'b1}}} : r_sum;
  end

  // Result registers, loaded only on the capture edge and held through DONE.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      RESULT_OUT     <= '0;
      RESULT_OVF_OUT <= 1'b0;
    end else if (capture) begin
      RESULT_OUT     <= r_val;
      RESULT_OVF_OUT <= MACC_OVF_IN | sat;
    end
  end

endmodule

// File: tb/tb_macc_p_sequencer.sv
// Testbench for macc_p_sequencer with NTERMS=2 and a behavioural MACC slice.
module tb_macc_p_sequencer;

  localparam int NT = 2;
  localparam int OW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, ready;
  logic [17:0]   intercept;
  logic          term_valid, term_ready;
  logic [17:0]   term_a;
  logic [15:0]   term_b;
  logic [17:0]   macc_a, macc_c;
  logic [15:0]   macc_b;
  logic [6:0]    macc_opmode;
  logic          macc_ce, macc_rst;
  logic [OW-1:0] macc_p;
  logic          macc_ovf;
  logic [OW-2:0] result;
  logic          result_ovf, result_valid, result_ready;
  logic [1:0]    dbg_state;

  // Slice stub controls.
  logic          stub_en;
  logic [OW-1:0] stub_p;
  logic          stub_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [17:0] icpt;
    logic [17:0] a0;
    logic [15:0] b0;
    logic [17:0] a1;
    logic [15:0] b1;
    int          stall;
    int          hold;
    logic        stub_en;
    logic [14:0] stub_p;
    logic        stub_ovf;
    logic [13:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[9];
  logic [14:0] exp_q[$];   // {ovf, result}
  logic [6:0]  op_trace[$];

  macc_p_sequencer #(.NTERMS(NT), .outwidth(OW)) dut (
    .CLK_IN(clk), .RST_IN(rst), .START_IN(start), .READY_OUT(ready),
    .INTERCEPT_IN(intercept), .TERM_VALID_IN(term_valid), .TERM_A_IN(term_a),
    .TERM_B_IN(term_b), .TERM_READY_OUT(term_ready), .MACC_A_OUT(macc_a),
    .MACC_B_OUT(macc_b), .MACC_C_OUT(macc_c), .MACC_OPMODE_OUT(macc_opmode),
    .MACC_CE_OUT(macc_ce), .MACC_RST_OUT(macc_rst), .MACC_P_IN(macc_p),
    .MACC_OVF_IN(macc_ovf), .RESULT_OUT(result), .RESULT_OVF_OUT(result_ovf),
    .RESULT_VALID_OUT(result_valid), .RESULT_READY_IN(result_ready),
    .DBG_STATE_OUT(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural DSP48E slice: AREG/BREG/CREG, MREG+OPMODEREG, PREG.
  logic signed [17:0] s_a, s_c;
  logic signed [15:0] s_b;
  logic signed [47:0] s_m, s_p;
  logic [6:0]         s_op;

  always @(posedge clk) begin
    if (macc_rst) begin
      s_a <= '0; s_b <= '0; s_c <= '0; s_m <= '0; s_p <= '0; s_op <= 7'h25;
    end else if (macc_ce) begin
      s_a  <= macc_a;
      s_b  <= macc_b;
      s_c  <= macc_c;
      s_m  <= 48'(s_a) * 48'(s_b);
      s_op <= macc_opmode;
      case (s_op[6:4])
        3'b011:  s_p <= (48'(s_c) <<< 18) + s_m;
        3'b010:  s_p <= s_p + s_m;
        default: s_p <= s_m;
      endcase
    end
  end

  assign macc_p   = stub_en ? stub_p : s_p[31:17];
  assign macc_ovf = stub_en ? stub_ovf : 1'b0;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [17:0] icpt, input logic [17:0] a0, input logic [15:0] b0,
                              input logic [17:0] a1, input logic [15:0] b1, input int stall,
                              input int hold, input logic se, input logic [14:0] sp, input logic so,
                              input logic [13:0] er, input logic eo);
    vec_t v;
    v.icpt = icpt; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.stall = stall; v.hold = hold; v.stub_en = se; v.stub_p = sp; v.stub_ovf = so;
    v.exp_res = er; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1);
  endtask

  // Drive one complete fit from the table and check it through the handshake.
  task automatic run_fit(input int i);
    vec_t        v;
    logic [14:0] exp;
    logic [13:0] held_res;
    logic        held_ovf;
    v = vecs[i];
    stub_en = v.stub_en; stub_p = v.stub_p; stub_ovf = v.stub_ovf;
    result_ready = 1'b0;
    op_trace.delete();
    wait_ready();
    start = 1'b1;
    intercept = v.icpt;
    exp_q.push_back({v.exp_ovf, v.exp_res});
    @(negedge clk);
    start = 1'b0;
    intercept = 18'($urandom_range(0, 262143));
    check("c_latch", macc_c, v.icpt);
    check("term_ready", term_ready, 1);
    for (int t = 0; t < NT; t++) begin
      if (t > 0) begin
        for (int s = 0; s < v.stall; s++) begin
          term_valid = 1'b0;
          term_a = 18'($urandom_range(1, 262143));
          term_b = 16'($urandom_range(1, 65535));
          @(negedge clk);
          check("bubble_ab", {macc_a, macc_b}, 0);
          op_trace.push_back(macc_opmode);
        end
      end
      term_valid = 1'b1;
      term_a = (t == 0) ? v.a0 : v.a1;
      term_b = (t == 0) ? v.b0 : v.b1;
      @(negedge clk);
      if (t > 0) op_trace.push_back(macc_opmode);
    end
    // Junk terms during DRAIN must be ignored.
    term_a = 18'($urandom_range(1, 262143));
    term_b = 16'($urandom_range(1, 65535));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      op_trace.push_back(macc_opmode);
      if (k == 2) check("drain_ignore_a", macc_a, 0);
      if (k == 3) check("valid_early", result_valid, 0);
      if (k == 4) check("latency", result_valid, 1);
    end
    term_valid = 1'b0;
    for (int k = 0; k < v.stall + 2; k++)
      check("opmode_seq", op_trace[k], (k == 0) ? 7'h35 : 7'h25);
    held_res = result;
    held_ovf = result_ovf;
    for (int h = 0; h < v.hold; h++) begin
      start = 1'b1;
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_stable", {result_ovf, result}, {held_ovf, held_res});
      check("hold_not_ready", ready, 0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    exp = exp_q.pop_front();
    check("result", result, exp[13:0]);
    check("result_ovf", result_ovf, exp[14]);
    @(negedge clk);
    result_ready = 1'b0;
    check("post_valid", result_valid, 0);
    check("post_ready", ready, 1);
    stub_en = 1'b0; stub_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; intercept = '0; term_valid = 1'b0;
    term_a = '0; term_b = '0; result_ready = 1'b0;
    stub_en = 1'b0; stub_p = '0; stub_ovf = 1'b0;

    vecs[0] = mk(18'd5,     18'd4096,    16'd64, 18'd4096,    16'd64, 0, 0, 0, 15'h0,    0, 14'd7,    0);
    vecs[1] = mk(18'd0,     18'd4096,    16'd32, 18'd0,       16'd0,  0, 0, 0, 15'h0,    0, 14'd1,    0);
    vecs[2] = mk(18'h3FFFE, 18'd0,       16'd0,  18'd0,       16'd0,  0, 0, 0, 15'h0,    0, 14'h3FFE, 0);
    vecs[3] = mk(18'd5,     18'd4096,    16'd64, 18'd4096,    16'd64, 3, 0, 0, 15'h0,    0, 14'd7,    0);
    vecs[4] = mk(18'd0,     18'd0,       16'd0,  18'd0,       16'd0,  0, 0, 1, 15'h3FFF, 0, 14'h1FFF, 1);
    vecs[5] = mk(18'd0,     18'd0,       16'd0,  18'd0,       16'd0,  0, 0, 1, 15'h0,    1, 14'd0,    1);
    vecs[6] = mk(18'd0,     18'h3F000,   16'd64, 18'd0,       16'd0,  0, 0, 0, 15'h0,    0, 14'h3FFF, 0);
    vecs[7] = mk(18'd0,     18'h3F000,   16'd32, 18'd0,       16'd0,  0, 0, 0, 15'h0,    0, 14'd0,    0);
    vecs[8] = mk(18'd3,     18'd8192,    16'd64, 18'h3F000,   16'd32, 1, 5, 0, 15'h0,    0, 14'd5,    0);

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_term_ready", term_ready, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", {result_ovf, result}, 0);
    check("rst_abc", {macc_a, macc_b, macc_c}, 0);
    check("rst_opmode", macc_opmode, 7'h25);
    check("rst_ce", macc_ce, 0);
    check("rst_macc_rst", macc_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rel_macc_rst", macc_rst, 0);
    check("rel_ce", macc_ce, 1);

    for (int i = 0; i < 9; i++) run_fit(i);

    // Reset after the first term aborts the fit with no result.
    wait_ready();
    start = 1'b1;
    intercept = 18'h01000;
    @(negedge clk);
    start = 1'b0;
    term_valid = 1'b1; term_a = 18'd4096; term_b = 16'd64;
    @(negedge clk);
    term_valid = 1'b0;
    check("abort_a_loaded", macc_a, 18'd4096);
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_term_ready", term_ready, 0);
    check("abort_valid", result_valid, 0);
    check("abort_abc", {macc_a, macc_b, macc_c}, 0);
    check("abort_opmode", macc_opmode, 7'h25);
    check("abort_ce_rst", {macc_ce, macc_rst}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_fit(0);
    run_fit(8);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
